// File: rtl/mux4x3_pkg.sv
// Shared definitions for the registered 4:1 word multiplexer:
// default data width, select encodings and the select type.
package mux4x3_pkg;

  localparam int MUX4X3_WIDTH = 3;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_W0 = 2'd0;
  localparam sel_t SEL_W1 = 2'd1;
  localparam sel_t SEL_W2 = 2'd2;
  localparam sel_t SEL_W3 = 2'd3;

endpackage

// File: rtl/mux4_comb.sv
// Purely combinational WIDTH-bit 4:1 multiplexer steered by a 2-bit select.
module mux4_comb
  import mux4x3_pkg::*;
#(
  parameter int WIDTH = MUX4X3_WIDTH
) (
  input  logic [WIDTH-1:0] w0,
  input  logic [WIDTH-1:0] w1,
  input  logic [WIDTH-1:0] w2,
  input  logic [WIDTH-1:0] w3,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y
);

  // Fully decoded selection; the default assignment keeps this latch-free.
  always_comb begin
    y = '0;
    case (sel)
      SEL_W0:  y = w0;
      SEL_W1:  y = w1;
      SEL_W2:  y = w2;
      SEL_W3:  y = w3;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mux4x3_reg.sv
// Registered 4:1 word multiplexer with one cycle of latency.
// Select index is {s1,s0}; f is cleared by a synchronous active-high rst.
// Build option MUX4X3_CE_EN adds a clock-enable input ce: with ce low the
// output holds, while rst still clears it regardless of ce.
module mux4x3_reg
  import mux4x3_pkg::*;
#(
  parameter int WIDTH = MUX4X3_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MUX4X3_CE_EN
  input  logic             ce,
`endif
  input  logic [WIDTH-1:0] w0,
  input  logic [WIDTH-1:0] w1,
  input  logic [WIDTH-1:0] w2,
  input  logic [WIDTH-1:0] w3,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] f
);

  sel_t             selIdx;
  logic [WIDTH-1:0] muxY;
  logic [WIDTH-1:0] f_d;
  logic [WIDTH-1:0] f_q;

  assign selIdx = {s1, s0};

  mux4_comb #(
    .WIDTH(WIDTH)
  ) u_mux (
    .w0  (w0),
    .w1  (w1),
    .w2  (w2),
    .w3  (w3),
    .sel (selIdx),
    .y   (muxY)
  );

  // Next output value: the selected word, or the held value when disabled.
  always_comb begin
    f_d = muxY;
`ifdef MUX4X3_CE_EN
    if (!ce) begin
      f_d = f_q;
    end
`endif
  end

  // Output register; rst takes priority over data and enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q <= '0;
    end else begin
      f_q <= f_d;
    end
  end

  assign f = f_q;

endmodule

// File: tb/tb_mux4x3_reg.sv
// Scoreboard bench for mux4x3_reg: the driver computes the expected output
// from a behavioural model and queues it; the monitor pops one entry per
// clock edge and compares against f.
module tb_mux4x3_reg;

  localparam int WIDTH = 3;

  logic             clk;
  logic             rst;
  logic             ce;
  logic [WIDTH-1:0] w0;
  logic [WIDTH-1:0] w1;
  logic [WIDTH-1:0] w2;
  logic [WIDTH-1:0] w3;
  logic             s0;
  logic             s1;
  logic [WIDTH-1:0] f;

  int checkCount;
  int errorCount;

  logic [WIDTH-1:0] expQ[$];
  string            nameQ[$];

  logic [WIDTH-1:0] modelF;

  mux4x3_reg #(
    .WIDTH(WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
`ifdef MUX4X3_CE_EN
    .ce  (ce),
`endif
    .w0  (w0),
    .w1  (w1),
    .w2  (w2),
    .w3  (w3),
    .s0  (s0),
    .s1  (s1),
    .f   (f)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs on the falling edge and queue the value f
  // must show after the following rising edge.
  task automatic applyStimulus(input string tag, input bit rV, input bit cV,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d,
                               input bit hi, input bit lo);
    logic [WIDTH-1:0] words[4];
    int               idx;
    bit               enable;
    @(negedge clk);
    rst = rV; ce = cV;
    w0 = a; w1 = b; w2 = c; w3 = d;
    s1 = hi; s0 = lo;
    words[0] = a; words[1] = b; words[2] = c; words[3] = d;
    idx = (hi ? 2 : 0) + (lo ? 1 : 0);
`ifdef MUX4X3_CE_EN
    enable = cV;
`else
    enable = 1'b1;
`endif
    if (rV)          modelF = '0;
    else if (enable) modelF = words[idx];
    expQ.push_back(modelF);
    nameQ.push_back(tag);
  endtask

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] expV);
    checkCount++;
    if (f !== expV) begin
      errorCount++;
      $display("[TB] FAIL %s: f=%0d expected %0d at %0t", tag, f, expV, $time);
    end
  endtask

  // Monitor: one result per rising edge, sampled 1 time unit after it.
  initial begin
    logic [WIDTH-1:0] e;
    string            n;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput(n, e);
      end
    end
  end

  // Directed plan followed by randomized traffic.
  initial begin
    int budget;
    checkCount = 0;
    errorCount = 0;
    modelF = '0;
    rst = 1'b1; ce = 1'b1;
    w0 = '0; w1 = '0; w2 = '0; w3 = '0; s0 = 1'b0; s1 = 1'b0;

    // Reset held for two edges, then release
    applyStimulus("reset0", 1, 1, 3'd5, 3'd0, 3'd0, 3'd0, 0, 0);
    applyStimulus("reset1", 1, 1, 3'd5, 3'd0, 3'd0, 3'd0, 0, 0);
    applyStimulus("resetRelease", 0, 1, 3'd5, 3'd0, 3'd0, 3'd0, 0, 0);

    // Select sweep
    applyStimulus("sweep00", 0, 1, 3'd1, 3'd2, 3'd4, 3'd7, 0, 0);
    applyStimulus("sweep01", 0, 1, 3'd1, 3'd2, 3'd4, 3'd7, 0, 1);
    applyStimulus("sweep10", 0, 1, 3'd1, 3'd2, 3'd4, 3'd7, 1, 0);
    applyStimulus("sweep11", 0, 1, 3'd1, 3'd2, 3'd4, 3'd7, 1, 1);

    // Bit order of s1/s0
    applyStimulus("bitOrderS0", 0, 1, 3'd0, 3'd6, 3'd3, 3'd0, 0, 1);
    applyStimulus("bitOrderS1", 0, 1, 3'd0, 3'd6, 3'd3, 3'd0, 1, 0);

    // Data tracking on w3 through the 7->0 wrap, other words randomized
    for (int i = 0; i < 10; i++) begin
      applyStimulus("trackW3", 0, 1, WIDTH'($urandom), WIDTH'($urandom),
                    WIDTH'($urandom), WIDTH'(i % 8), 1, 1);
    end

    // Reset in the middle of traffic
    applyStimulus("midPre", 0, 1, 3'd0, 3'd0, 3'd4, 3'd0, 1, 0);
    applyStimulus("midReset", 1, 1, 3'd0, 3'd0, 3'd4, 3'd0, 1, 0);
    applyStimulus("midResume", 0, 1, 3'd0, 3'd0, 3'd4, 3'd0, 1, 0);

`ifdef MUX4X3_CE_EN
    applyStimulus("ceLoad", 0, 1, 3'd0, 3'd2, 3'd0, 3'd0, 0, 1);
    applyStimulus("ceHold", 0, 0, 3'd0, 3'd5, 3'd0, 3'd0, 0, 1);
    applyStimulus("ceHold2", 0, 0, 3'd0, 3'd5, 3'd0, 3'd0, 0, 1);
    applyStimulus("ceReload", 0, 1, 3'd0, 3'd5, 3'd0, 3'd0, 0, 1);
    applyStimulus("ceResetPrio", 1, 0, 3'd0, 3'd5, 3'd0, 3'd0, 0, 1);
`endif

    // Randomized traffic with occasional reset and enable drops
    for (int i = 0; i < 200; i++) begin
      applyStimulus("random", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                    WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                    WIDTH'($urandom), 1'($urandom), 1'($urandom));
    end

    // Drain the scoreboard with a bounded wait
    budget = 0;
    while (expQ.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (expQ.size() > 0) begin
      errorCount++;
      $display("[TB] FAIL drain: %0d results pending, expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
